instr_encoder_loader: RTL and testbench

//  Encoder counterpart of the pipeline's opcode/funct control decoder: accepts symbolic

---
 rtl/mips_isa_pkg.sv | 94 +++++++++
 rtl/instr_encode.sv | 45 ++++
 rtl/instr_encoder_loader.sv | 82 ++++++++
 tb/tb_instr_encoder_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS mnemonic codes, opcode/funct constants and word packers
package mips_isa_pkg;

    // Symbolic instruction codes carried on in_mnem; codes above MN_BGEZ are illegal
    typedef enum logic [4:0] {
        MN_NOP  = 5'd0,
        MN_ADD  = 5'd1,
        MN_SUB  = 5'd2,
        MN_AND  = 5'd3,
        MN_OR   = 5'd4,
        MN_SLT  = 5'd5,
        MN_NOR  = 5'd6,
        MN_XOR  = 5'd7,
        MN_SLL  = 5'd8,
        MN_SRL  = 5'd9,
        MN_JR   = 5'd10,
        MN_ADDI = 5'd11,
        MN_ORI  = 5'd12,
        MN_XORI = 5'd13,
        MN_LW   = 5'd14,
        MN_SW   = 5'd15,
        MN_BEQ  = 5'd16,
        MN_BNE  = 5'd17,
        MN_J    = 5'd18,
        MN_JAL  = 5'd19,
        MN_BLTZ = 5'd20,
        MN_BGEZ = 5'd21
    } mnem_e;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    // REGIMM branches select the condition through the rt field
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    // funct field for an R-type mnemonic; zero for anything else
    function automatic logic [5:0] rtype_funct(input logic [4:0] m);
        logic [5:0] f;
        f = 6'h00;
        case (m)
            MN_ADD: f = F_ADD;
            MN_SUB: f = F_SUB;
            MN_AND: f = F_AND;
            MN_OR:  f = F_OR;
            MN_SLT: f = F_SLT;
            MN_NOR: f = F_NOR;
            MN_XOR: f = F_XOR;
            MN_SLL: f = F_SLL;
            MN_SRL: f = F_SRL;
            MN_JR:  f = F_JR;
            default: f = 6'h00;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - combinational packer from mnemonic + fields to a 32-bit MIPS word
module instr_encode
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the format per mnemonic; fields the format does not use are forced to zero
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (mnem)
            MN_NOP:  word = 32'h0;
            MN_ADD, MN_SUB, MN_AND, MN_OR, MN_SLT, MN_NOR, MN_XOR:
                     word = pack_r(rs, rt, rd, 5'd0, rtype_funct(mnem));
            MN_SLL, MN_SRL:
                     word = pack_r(5'd0, rt, rd, shamt, rtype_funct(mnem));
            MN_JR:   word = pack_r(rs, 5'd0, 5'd0, 5'd0, F_JR);
            MN_ADDI: word = pack_i(OP_ADDI, rs, rt, imm);
            MN_ORI:  word = pack_i(OP_ORI,  rs, rt, imm);
            MN_XORI: word = pack_i(OP_XORI, rs, rt, imm);
            MN_LW:   word = pack_i(OP_LW,   rs, rt, imm);
            MN_SW:   word = pack_i(OP_SW,   rs, rt, imm);
            MN_BEQ:  word = pack_i(OP_BEQ,  rs, rt, imm);
            MN_BNE:  word = pack_i(OP_BNE,  rs, rt, imm);
            MN_BLTZ: word = pack_i(OP_REGIMM, rs, RT_BLTZ, imm);
            MN_BGEZ: word = pack_i(OP_REGIMM, rs, RT_BGEZ, imm);
            MN_J:    word = pack_j(OP_J,   target);
            MN_JAL:  word = pack_j(OP_JAL, target);
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - streams encoded instructions into imem at consecutive addresses
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    // count value at which the accepted word is the last one that fits
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;

    instr_encode u_encode (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // clr blocks the handshake in the same cycle so nothing is lost across a restart
    assign in_ready = !full && !clr;
    assign accept   = in_valid && in_ready;

    // Output register stage, write pointer and sticky full/err flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            count      <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else if (clr) begin
            imem_we <= 1'b0;
            count   <= '0;
            full    <= 1'b0;
            err     <= 1'b0;
        end else begin
            imem_we <= accept && enc_legal;
            if (accept && enc_legal) begin
                imem_addr  <= count[ADDR_W-1:0];
                imem_wdata <= enc_word;
                count      <= count + ONE;
                if (count == LAST) begin
                    full <= 1'b1;
                end
            end
            if (accept && !enc_legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;
    import mips_isa_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int tests_run = 0;
    int tests_failed = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mnem    (in_mnem),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
        in_mnem   = m;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_imm    = imm;
        in_target = tgt;
        in_valid  = 1'b1;
        tick();
    endtask

    task automatic pulse_clr();
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Expect one write with the given address/data and resulting count
    task automatic expect_wr(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [ADDR_W:0] c);
        check({tag, "_we"},    imem_we,    1);
        check({tag, "_addr"},  imem_addr,  a);
        check({tag, "_wdata"}, imem_wdata, d);
        check({tag, "_count"}, count,      c);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; in_imm = '0; in_target = '0;
        #12;
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // 1: single add
        put(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        expect_wr("t1_add", 2'd0, 32'h00221820, 3'd1);
        in_valid = 1'b0;
        tick();
        check("t1_idle_we", imem_we, 0);
        check("t1_idle_wdata", imem_wdata, 32'h00221820);

        // 2: back-to-back I-type
        pulse_clr();
        check("t2_clr_count", count, 0);
        put(MN_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
        expect_wr("t2_addi", 2'd0, 32'h20080005, 3'd1);
        put(MN_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        expect_wr("t2_beq", 2'd1, 32'h1022FFFF, 3'd2);

        // 3/4: formats, then fill to DEPTH and try a fifth word
        pulse_clr();
        put(MN_BGEZ, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0003, 26'h0);
        expect_wr("t3_bgez", 2'd0, 32'h04810003, 3'd1);
        put(MN_BLTZ, 5'd4, 5'd7, 5'd0, 5'd0, 16'h0003, 26'h0);
        expect_wr("t3_bltz", 2'd1, 32'h04800003, 3'd2);
        put(MN_SLL, 5'd9, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);
        expect_wr("t3_sll", 2'd2, 32'h00031100, 3'd3);
        put(MN_JR, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
        expect_wr("t3_jr", 2'd3, 32'h03E00008, 3'd4);
        check("t4_full", full, 1);
        put(MN_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        check("t4_ready_low", in_ready, 0);
        check("t4_no_write", imem_we, 0);
        check("t4_count_hold", count, 4);
        check("t4_addr_hold", imem_addr, 3);
        pulse_clr();
        check("t4_clr_full", full, 0);
        put(MN_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
        expect_wr("t3_jal", 2'd0, 32'h0C000040, 3'd1);

        // 5: illegal mnemonic followed by add
        pulse_clr();
        put(5'h1F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        check("t5_ill_we", imem_we, 0);
        check("t5_ill_err", err, 1);
        check("t5_ill_count", count, 0);
        put(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        expect_wr("t5_add", 2'd0, 32'h00221820, 3'd1);
        check("t5_err_sticky", err, 1);

        // 6: clr concurrent with accept after two writes
        pulse_clr();
        put(MN_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0);
        expect_wr("t6_ori", 2'd0, 32'h34221234, 3'd1);
        put(MN_SW, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0);
        expect_wr("t6_sw", 2'd1, 32'hAC640010, 3'd2);
        in_mnem = MN_ADD;
        clr = 1'b1;
        #1;
        check("t6_clr_ready", in_ready, 0);
        tick();
        clr = 1'b0;
        check("t6_clr_we", imem_we, 0);
        check("t6_clr_count", count, 0);
        check("t6_clr_err", err, 0);

        // 6: async reset in the middle of a pending write
        put(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        check("t6_pre_rst_we", imem_we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_arst_we", imem_we, 0);
        check("t6_arst_wdata", imem_wdata, 0);
        check("t6_arst_count", count, 0);
        in_valid = 1'b0;
        #4;
        rst_n = 1'b1;
        tick();
        check("t6_post_rst_we", imem_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
